bram_req_scheduler: RTL

Pipelined, starvation-aware scheduler that shares one single-port BRAM (1-cycle read latency) between NUM_REQ lock-in requesters. It accepts at most one read or write per cycle, drives the BRAM native port directly, and returns read data in order with a per-requester response-valid pulse. It sits between the lock-in compute channels and the BRAM primitive. It replaces the idle/wait adapter with a 1-request-per-cycle pipeline and adds an aging override so no requester starves.

---
 rtl/bram_req_scheduler.sv | 133 +++++++++++++
 1 files changed

// File: rtl/bram_req_scheduler.sv
// Shares one single-port BRAM between NUM_REQ requesters: one accept per cycle,
// round-robin arbitration with an aging override, in-order read responses.

module bram_req_age_cnt #(
  parameter int LIMIT = 15,
  parameter int CNT_W = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic valid,
  input  logic accept,
  output logic sat
);
  logic [CNT_W-1:0] cnt;

  // Disabled cycles still age a pending request.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                         cnt <= '0;
    else if (!valid || accept)         cnt <= '0;
    else if (cnt != CNT_W'(LIMIT))     cnt <= cnt + 1'b1;
  end

  assign sat = (cnt == CNT_W'(LIMIT));
endmodule

module bram_req_scheduler #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 32,
  parameter int NUM_REQ      = 8,
  parameter int STARVE_LIMIT = 15
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  sched_en,
  input  logic [NUM_REQ-1:0]    req_valid,
  output logic [NUM_REQ-1:0]    req_ready,
  input  logic [NUM_REQ-1:0]    req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr  [NUM_REQ],
  input  logic [DATA_WIDTH-1:0] req_wdata [NUM_REQ],
  output logic [NUM_REQ-1:0]    resp_valid,
  output logic [DATA_WIDTH-1:0] resp_data [NUM_REQ],
  output logic                  bram_en,
  output logic                  bram_we,
  output logic [ADDR_WIDTH-1:0] bram_addr,
  output logic [DATA_WIDTH-1:0] bram_din,
  input  logic [DATA_WIDTH-1:0] bram_dout,
  output logic                  busy,
  output logic                  starve_evt
);
  localparam int CH_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

  logic [NUM_REQ-1:0] age_sat;
  logic [CH_W-1:0]    last_grant;
  logic [CH_W-1:0]    ovr_idx, rr_idx, grant_idx;
  logic               ovr_hit, rr_hit, grant_any;
  int                 rr_j;

  // vld_pipe[1]: read issued to BRAM; vld_pipe[2]: bram_dout valid this cycle
  logic [2:1]         vld_pipe;
  logic [CH_W-1:0]    ch_pipe [2:1];

  bram_req_age_cnt #(.LIMIT(STARVE_LIMIT), .CNT_W(CNT_W)) u_age [NUM_REQ-1:0] (
    .clk    (clk),
    .reset  (reset),
    .valid  (req_valid),
    .accept (req_ready),
    .sat    (age_sat)
  );

  // Descending loops so the last hit written is the lowest index / nearest RR slot.
  always_comb begin
    ovr_hit   = 1'b0;
    ovr_idx   = '0;
    rr_hit    = 1'b0;
    rr_idx    = '0;
    rr_j      = 0;
    req_ready = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_valid[i] && age_sat[i]) begin
        ovr_hit = 1'b1;
        ovr_idx = CH_W'(i);
      end
    end
    for (int k = NUM_REQ; k >= 1; k--) begin
      rr_j = int'(last_grant) + k;
      if (rr_j >= NUM_REQ) rr_j = rr_j - NUM_REQ;
      if (req_valid[rr_j]) begin
        rr_hit = 1'b1;
        rr_idx = CH_W'(rr_j);
      end
    end
    grant_any = sched_en && (ovr_hit || rr_hit);
    grant_idx = ovr_hit ? ovr_idx : rr_idx;
    if (grant_any) req_ready[grant_idx] = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bram_en    <= 1'b0;
      bram_we    <= 1'b0;
      bram_addr  <= '0;
      bram_din   <= '0;
      last_grant <= CH_W'(NUM_REQ - 1);
      starve_evt <= 1'b0;
      vld_pipe   <= '0;
      ch_pipe[1] <= '0;
      ch_pipe[2] <= '0;
      resp_valid <= '0;
      for (int i = 0; i < NUM_REQ; i++) resp_data[i] <= '0;
    end else begin
      bram_en    <= grant_any;
      bram_we    <= grant_any && req_we[grant_idx];
      starve_evt <= grant_any && ovr_hit;
      if (grant_any) begin
        bram_addr  <= req_addr[grant_idx];
        bram_din   <= req_wdata[grant_idx];
        last_grant <= grant_idx;
      end
      vld_pipe[1] <= grant_any && !req_we[grant_idx];
      ch_pipe[1]  <= grant_idx;
      vld_pipe[2] <= vld_pipe[1];
      ch_pipe[2]  <= ch_pipe[1];
      resp_valid  <= '0;
      if (vld_pipe[2]) begin
        resp_valid[ch_pipe[2]] <= 1'b1;
        resp_data[ch_pipe[2]]  <= bram_dout;
      end
    end
  end

  assign busy = |vld_pipe;
endmodule
